ftoi_pipe: RTL and testbench

- Converts an IEEE-754 single-precision operand to a signed 32-bit two's-complement integer. It is the inverse of the FPU's int-to-float unit.
- Sits in the FPU execute slot beside the other conversion units, with the same en/ready pulse handshake.
- Two-stage pipeline: stage 1 decodes and classifies, stage 2 shifts, rounds and negates.
- Accepts one operation per cycle with no stalls.

---
 rtl/ftoi_if.sv | 23 ++
 rtl/ftoi_pipe.sv | 107 ++++++++++
 tb/tb_ftoi_pipe.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ftoi_if.sv
// Operand/result handshake between the FPU execute slot and the float-to-int unit.
interface ftoi_if;
  logic [31:0] a;
  logic        en;
  logic [31:0] res;
  logic        ready;

  // Issuer: drives the operand and the valid pulse, receives the result.
  modport master (
    output a,
    output en,
    input  res,
    input  ready
  );

  // Converter: consumes the operand, produces the registered result.
  modport slave (
    input  a,
    input  en,
    output res,
    output ready
  );
endinterface

// File: rtl/ftoi_pipe.sv
// Two-stage IEEE-754 single to signed 32-bit integer converter.
// Stage 1 decodes and classifies the operand. Stage 2 shifts, rounds,
// saturates and negates. It accepts one operation per cycle, with no stalls.
module ftoi_pipe #(
  parameter int ROUND_MODE = 0  // 0: nearest, ties away from zero; 1: truncate
) (
  input  logic   clk,
  input  logic   rst,
  ftoi_if.slave  bus
);

  // Stage 1 state
  logic               v1_reg;
  logic               sign1_reg;
  logic signed [8:0]  e1_reg;
  logic [23:0]        m1_reg;
  logic               zero1_reg;
  logic               inf1_reg;
  logic               nan1_reg;

  // Stage 2 state
  logic               ready_reg;
  logic [31:0]        res_reg;

  // Stage 2 combinational values
  logic [4:0]         shift_r;
  logic [2:0]         shift_l;
  logic [24:0]        ext;
  logic [31:0]        mag;
  logic [31:0]        res_next;

  // Stage 1: capture the decoded operand; the valid bit is cleared by reset,
  // and an en that arrives during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      sign1_reg <= 1'b0;
      e1_reg    <= '0;
      m1_reg    <= '0;
      zero1_reg <= 1'b0;
      inf1_reg  <= 1'b0;
      nan1_reg  <= 1'b0;
    end else begin
      v1_reg <= bus.en;
      if (bus.en) begin
        sign1_reg <= bus.a[31];
        e1_reg    <= $signed({1'b0, bus.a[30:23]} - 9'd127);
        m1_reg    <= {1'b1, bus.a[22:0]};
        zero1_reg <= (bus.a[30:23] == 8'd0);
        inf1_reg  <= (bus.a[30:23] == 8'hFF) && (bus.a[22:0] == 23'd0);
        nan1_reg  <= (bus.a[30:23] == 8'hFF) && (bus.a[22:0] != 23'd0);
      end
    end
  end

  // Stage 2 datapath: compute the magnitude, then select a saturated or signed result.
  always_comb begin
    // Right-shift path for exponents 0..22. The mantissa is widened with one
    // extra LSB, so bit 0 of ext is the bit just below the integer point.
    shift_r  = 5'd23 - e1_reg[4:0];
    ext      = {m1_reg, 1'b0} >> shift_r;
    // Left-shift path for exponents 23..30: (e - 23) mod 8 equals e[2:0] + 1.
    shift_l  = e1_reg[2:0] + 3'd1;
    mag      = 32'd0;
    res_next = 32'd0;

    if (e1_reg < -9'sd1) begin
      mag = 32'd0;
    end else if (e1_reg == -9'sd1) begin
      // The value lies in [0.5, 1), so nearest rounding always gives 1.
      mag = (ROUND_MODE == 0) ? 32'd1 : 32'd0;
    end else if (e1_reg <= 9'sd22) begin
      mag = {8'd0, ext[24:1]} + {31'd0, (ROUND_MODE == 0) && ext[0]};
    end else begin
      mag = {8'd0, m1_reg} << shift_l;
    end

    // Saturation takes priority over the magnitude path. Exactly -2^31
    // falls into the negative saturation case and gives the same encoding.
    if (nan1_reg) begin
      res_next = 32'h7FFF_FFFF;
    end else if (inf1_reg || (!zero1_reg && (e1_reg >= 9'sd31))) begin
      res_next = sign1_reg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (zero1_reg) begin
      res_next = 32'd0;
    end else begin
      res_next = sign1_reg ? (32'd0 - mag) : mag;
    end
  end

  // Stage 2 registers: ready follows the stage 1 valid bit, and res holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_reg <= 1'b0;
      res_reg   <= 32'd0;
    end else begin
      ready_reg <= v1_reg;
      if (v1_reg) begin
        res_reg <= res_next;
      end
    end
  end

  assign bus.res   = res_reg;
  assign bus.ready = ready_reg;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed bench for ftoi_pipe. A nearest-rounding instance and a truncating
// instance receive the same operands, and each output is compared with
// hand-computed values.
module tb_ftoi_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ftoi_if if_n ();
  ftoi_if if_t ();

  ftoi_pipe #(.ROUND_MODE(0)) dut_n (.clk(clk), .rst(rst), .bus(if_n));
  ftoi_pipe #(.ROUND_MODE(1)) dut_t (.clk(clk), .rst(rst), .bus(if_t));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Values observed by send_op
  logic        obs_early_n, obs_early_t;
  logic        obs_rdy_n, obs_rdy_t;
  logic [31:0] obs_res_n, obs_res_t;
  logic        obs_after_n, obs_after_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] val, input logic en);
    if_n.a  = val;
    if_t.a  = val;
    if_n.en = en;
    if_t.en = en;
  endtask

  // Issue one operation and record ready one cycle early, on time and one cycle late.
  task automatic send_op(input logic [31:0] val);
    drive(val, 1'b1);
    tick();
    drive(32'd0, 1'b0);
    obs_early_n = if_n.ready;
    obs_early_t = if_t.ready;
    tick();
    obs_rdy_n = if_n.ready;
    obs_res_n = if_n.res;
    obs_rdy_t = if_t.ready;
    obs_res_t = if_t.res;
    tick();
    obs_after_n = if_n.ready;
    obs_after_t = if_t.ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h3F80_0000, 1'b1);
    tick();
    tick();
    checks++;
    if (if_n.res !== 32'd0 || if_n.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_n: res=%h ready=%b, required res=00000000 ready=0", if_n.res, if_n.ready);
    end
    checks++;
    if (if_t.res !== 32'd0 || if_t.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_t: res=%h ready=%b, required res=00000000 ready=0", if_t.res, if_t.ready);
    end
    rst = 1'b0;
    drive(32'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (if_n.ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_en_ignored cycle %0d: ready=%b, required 0", i, if_n.ready);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    send_op(32'h3F80_0000);
    checks++;
    if (obs_early_n !== 1'b0 || obs_rdy_n !== 1'b1 || obs_after_n !== 1'b0) begin
      errors++;
      $display("FAIL basic_timing: ready early/ontime/late=%b%b%b, required 010",
               obs_early_n, obs_rdy_n, obs_after_n);
    end
    checks++;
    if (obs_res_n !== 32'h0000_0001 || obs_res_t !== 32'h0000_0001) begin
      errors++;
      $display("FAIL basic_res: res_n=%h res_t=%h, required 00000001", obs_res_n, obs_res_t);
    end
    checks++;
    if (if_n.res !== 32'h0000_0001) begin
      errors++;
      $display("FAIL basic_hold: res=%h, required 00000001 while idle", if_n.res);
    end
    $display("test_basic: a=3f800000 res_n=%h res_t=%h", obs_res_n, obs_res_t);
  endtask

  task automatic test_rounding();
    logic [31:0] vin  [8];
    logic [31:0] vexn [8];
    logic [31:0] vext [8];
    vin[0] = 32'h4020_0000; vexn[0] = 32'h0000_0003; vext[0] = 32'h0000_0002;
    vin[1] = 32'hC020_0000; vexn[1] = 32'hFFFF_FFFD; vext[1] = 32'hFFFF_FFFE;
    vin[2] = 32'h3F00_0000; vexn[2] = 32'h0000_0001; vext[2] = 32'h0000_0000;
    vin[3] = 32'h3EFF_FFFF; vexn[3] = 32'h0000_0000; vext[3] = 32'h0000_0000;
    vin[4] = 32'h3FC0_0000; vexn[4] = 32'h0000_0002; vext[4] = 32'h0000_0001;
    vin[5] = 32'h4EFF_FFFF; vexn[5] = 32'h7FFF_FF80; vext[5] = 32'h7FFF_FF80;
    vin[6] = 32'h3F7F_FFFF; vexn[6] = 32'h0000_0001; vext[6] = 32'h0000_0000;
    vin[7] = 32'h4B00_0001; vexn[7] = 32'h0080_0001; vext[7] = 32'h0080_0001;
    for (int i = 0; i < 8; i++) begin
      send_op(vin[i]);
      checks++;
      if (obs_rdy_n !== 1'b1 || obs_res_n !== vexn[i]) begin
        errors++;
        $display("FAIL round_nearest a=%h: ready=%b res=%h, required ready=1 res=%h",
                 vin[i], obs_rdy_n, obs_res_n, vexn[i]);
      end
      checks++;
      if (obs_rdy_t !== 1'b1 || obs_res_t !== vext[i]) begin
        errors++;
        $display("FAIL round_trunc a=%h: ready=%b res=%h, required ready=1 res=%h",
                 vin[i], obs_rdy_t, obs_res_t, vext[i]);
      end
      $display("test_rounding: a=%h res_n=%h res_t=%h", vin[i], obs_res_n, obs_res_t);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] vin [8];
    logic [31:0] vex [8];
    vin[0] = 32'h4F00_0000; vex[0] = 32'h7FFF_FFFF;
    vin[1] = 32'hCF00_0000; vex[1] = 32'h8000_0000;
    vin[2] = 32'h7F80_0000; vex[2] = 32'h7FFF_FFFF;
    vin[3] = 32'hFF80_0000; vex[3] = 32'h8000_0000;
    vin[4] = 32'h7FC0_0000; vex[4] = 32'h7FFF_FFFF;
    vin[5] = 32'hFFC0_0000; vex[5] = 32'h7FFF_FFFF;
    vin[6] = 32'h8000_0000; vex[6] = 32'h0000_0000;
    vin[7] = 32'h0000_0001; vex[7] = 32'h0000_0000;
    for (int i = 0; i < 8; i++) begin
      send_op(vin[i]);
      checks++;
      if (obs_rdy_n !== 1'b1 || obs_res_n !== vex[i] || obs_res_t !== vex[i]) begin
        errors++;
        $display("FAIL special a=%h: ready=%b res_n=%h res_t=%h, required ready=1 res=%h",
                 vin[i], obs_rdy_n, obs_res_n, obs_res_t, vex[i]);
      end
      $display("test_saturation: a=%h res_n=%h res_t=%h", vin[i], obs_res_n, obs_res_t);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vin  [5];
    logic [31:0] vexn [5];
    logic [31:0] vext [5];
    vin[0] = 32'h3F80_0000; vexn[0] = 32'h0000_0001; vext[0] = 32'h0000_0001;
    vin[1] = 32'hBF80_0000; vexn[1] = 32'hFFFF_FFFF; vext[1] = 32'hFFFF_FFFF;
    vin[2] = 32'h4020_0000; vexn[2] = 32'h0000_0003; vext[2] = 32'h0000_0002;
    vin[3] = 32'h4B00_0001; vexn[3] = 32'h0080_0001; vext[3] = 32'h0080_0001;
    vin[4] = 32'h0000_0000; vexn[4] = 32'h0000_0000; vext[4] = 32'h0000_0000;
    for (int c = 0; c < 7; c++) begin
      if (c < 5) drive(vin[c], 1'b1);
      else       drive(32'd0, 1'b0);
      tick();
      if (c >= 1 && c <= 5) begin
        checks++;
        if (if_n.ready !== 1'b1 || if_n.res !== vexn[c-1] ||
            if_t.ready !== 1'b1 || if_t.res !== vext[c-1]) begin
          errors++;
          $display("FAIL b2b op %0d: ready=%b%b res_n=%h res_t=%h, required ready=11 res_n=%h res_t=%h",
                   c - 1, if_n.ready, if_t.ready, if_n.res, if_t.res, vexn[c-1], vext[c-1]);
        end
        $display("test_back_to_back: op %0d res_n=%h res_t=%h", c - 1, if_n.res, if_t.res);
      end else begin
        checks++;
        if (if_n.ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b idle cycle %0d: ready=%b, required 0", c, if_n.ready);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    drive(32'h4020_0000, 1'b1);
    tick();
    drive(32'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (if_n.ready !== 1'b0 || if_n.res !== 32'd0 || if_t.ready !== 1'b0 || if_t.res !== 32'd0) begin
        errors++;
        $display("FAIL midflight cycle %0d: ready=%b%b res_n=%h res_t=%h, required ready=00 res=0",
                 i, if_n.ready, if_t.ready, if_n.res, if_t.res);
      end
      tick();
    end
    send_op(32'h3F80_0000);
    checks++;
    if (obs_rdy_n !== 1'b1 || obs_res_n !== 32'h0000_0001) begin
      errors++;
      $display("FAIL midflight_recover: ready=%b res=%h, required ready=1 res=00000001",
               obs_rdy_n, obs_res_n);
    end
    $display("test_reset_midflight: recovered res_n=%h", obs_res_n);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(32'd0, 1'b0);
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
